rom_burst_arbiter: RTL and testbench
====================================

// Module: rom_burst_arbiter
// PURPOSE
// - Shares one single-port ROM macro (1-cycle read latency) between two burst requesters.
// - Typical pairing: port 0 = CPU/AXI slave wrapper, port 1 = boot loader / DMA.
// - Arbitrates whole bursts and sequences ROM addressing (incrementing, word-addressed).
// - Streams ROM_out back to the granted requester with valid/ready backpressure.
// PARAMETERS
// - ADDR_W  12  ROM word-address width
// - DATA_W  32  ROM data width
// - LEN_W   4   burst length field width; len = beats-1
// PORTS
// - clk         in   1       clock, all logic on posedge
// - rst         in   1       synchronous reset, active-high
// - reqN_valid  in   1       requester N (N=0,1) burst request
// - reqN_addr   in   ADDR_W  burst start word address
// - reqN_len    in   LEN_W   beats-1
// - reqN_ready  out  1       request accepted this cycle (valid&ready)
// - rspN_data   out  DATA_W  read beat data
// - rspN_valid  out  1       beat valid
// - rspN_last   out  1       final beat of burst
// - rspN_ready  in   1       requester accepts beat
// - ROM_out     in   DATA_W  ROM read data, valid 1 cycle after read
// - ROM_read    out  1       ROM read strobe
// - ROM_enable  out  1       ROM chip enable
// - ROM_address out  ADDR_W  ROM word address
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, rr_ptr=0 (port 0 favoured), cnt=0.
//   Held at 0 while in IDLE, including during reset: reqN_ready, rspN_valid, rspN_last,
//   ROM_read, ROM_enable. rspN_data=ROM_out always.
// - States: IDLE, FIRST, STREAM.
// - IDLE
//   - At most one reqN_ready=1, combinational on reqN_valid.
//   - Both valid: grant port rr_ptr. One valid: grant it.
//   - On grant: latch owner, addr, len; cnt=0; rr_ptr=~owner; go FIRST.
// - FIRST (1 cycle)
//   - ROM_read=ROM_enable=1, ROM_address=base.
//   - No rsp valid. Go STREAM.
// - STREAM
//   - rsp<owner>_valid=1, data=ROM_out; rsp_last=(cnt==len). Other port rsp_valid=0.
//   - Beat handshake (valid&ready), not last: cnt+=1; ROM_address=base+cnt+1 this cycle.
//   - rsp_ready=0: ROM_address=base+cnt re-read, so data stays stable.
//   - ROM_read=ROM_enable=1 throughout.
//   - Handshake on last beat: go IDLE. New request is acceptable the following cycle.
// - Latency: accept at cycle T -> ROM read at T+1 -> first rsp_valid at T+2.
//   Full rate thereafter, 1 beat/cycle with ready held high.
// - Address arithmetic: modulo 2^ADDR_W; 0xFFF+1 wraps to 0x000 inside a burst.
// - Burst is never pre-empted. Requests arriving mid-burst wait; reqN_ready stays 0.
// - reqN_valid deasserting before grant is legal; no state change.
// - rst mid-burst: abort immediately. Next cycle IDLE, all valids 0, burst discarded.
// - No write path. ROM contents are never modified.
// CONFIGURATION
// - ROM_ARB_PRIO_EN defined: fixed priority. Port 0 always wins simultaneous requests.
//   rr_ptr is removed; port 1 can starve.
// - ROM_ARB_PRIO_EN undefined (default): round-robin via rr_ptr as above.
// TESTING
// - rst, then req0 addr=0x010 len=3, rsp0_ready=1
//   -> rsp0 beats = ROM[0x010..0x013] at T+2..T+5; last on 4th beat; IDLE at T+6.
// - req0 and req1 both valid in same cycle after reset, len=0 each
//   -> port 0 served first, then port 1. Repeat -> port 0 again (round-robin alternation).
// - Same as above with ROM_ARB_PRIO_EN
//   -> port 0 wins every time port 0 and port 1 collide.
// - req1 addr=0xFFE len=3, rsp1_ready toggling 1,0,1,0
//   -> data ROM[0xFFE],[0xFFF],[0x000],[0x001]; data stable while ready=0; no beat lost or duplicated.
// - req0 len=7 granted; req1 raised at beat 2
//   -> req1_ready=0 until port 0's last handshake; req1 granted in the following IDLE cycle.
// - rst asserted at beat 3 of an 8-beat burst
//   -> next cycle all rsp valids=0, ROM_enable=0; fresh request then completes normally.

Source files
------------

// File: rtl/rom_burst_arbiter_if.sv
// Bus bundle for rom_burst_arbiter: two burst request/response ports plus the ROM macro pins.
// The arbiter uses the slave modport; requesters and the ROM model drive the master side.
interface rom_burst_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [LEN_W-1:0]  req0_len;
  logic              req0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_valid;
  logic              rsp0_last;
  logic              rsp0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [LEN_W-1:0]  req1_len;
  logic              req1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_valid;
  logic              rsp1_last;
  logic              rsp1_ready;

  logic [DATA_W-1:0] ROM_out;
  logic              ROM_read;
  logic              ROM_enable;
  logic [ADDR_W-1:0] ROM_address;

  modport slave (
    input  req0_valid, req0_addr, req0_len, rsp0_ready,
    input  req1_valid, req1_addr, req1_len, rsp1_ready,
    input  ROM_out,
    output req0_ready, rsp0_data, rsp0_valid, rsp0_last,
    output req1_ready, rsp1_data, rsp1_valid, rsp1_last,
    output ROM_read, ROM_enable, ROM_address
  );

  modport master (
    output req0_valid, req0_addr, req0_len, rsp0_ready,
    output req1_valid, req1_addr, req1_len, rsp1_ready,
    output ROM_out,
    input  req0_ready, rsp0_data, rsp0_valid, rsp0_last,
    input  req1_ready, rsp1_data, rsp1_valid, rsp1_last,
    input  ROM_read, ROM_enable, ROM_address
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Shares a 1-cycle-latency ROM between two burst requesters, arbitrating whole bursts.
// Define ROM_ARB_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module rom_burst_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic clk,
  input  logic rst,
  rom_burst_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FIRST, STREAM} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rom_en_q, rom_en_d;
  logic              rsp_valid_q, rsp_valid_d;
`ifndef ROM_ARB_PRIO_EN
  logic              rr_q, rr_d;
`endif

  logic              grant0, grant1;
  logic              owner_ready;
  logic              beat_hs;
  logic              is_last;
  logic              advance;
  logic [ADDR_W-1:0] addr_off;

  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign beat_hs     = rsp_valid_q & owner_ready;
  assign is_last     = (cnt_q == len_q);
  assign advance     = beat_hs & ~is_last;

  // On a stalled beat the current address is re-read so ROM_out holds the same word.
  assign addr_off        = ADDR_W'(cnt_q) + ADDR_W'(advance);
  assign bus.ROM_address = base_q + addr_off;
  assign bus.ROM_read    = rom_en_q;
  assign bus.ROM_enable  = rom_en_q;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_data  = bus.ROM_out;
  assign bus.rsp1_data  = bus.ROM_out;
  assign bus.rsp0_valid = rsp_valid_q & ~owner_q;
  assign bus.rsp1_valid = rsp_valid_q &  owner_q;
  assign bus.rsp0_last  = bus.rsp0_valid & is_last;
  assign bus.rsp1_last  = bus.rsp1_valid & is_last;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rom_en_d    = rom_en_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ROM_ARB_PRIO_EN
    rr_d        = rr_q;
`endif
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
`ifdef ROM_ARB_PRIO_EN
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid & ~bus.req0_valid;
`else
          if (bus.req0_valid && bus.req1_valid) begin
            grant0 = ~rr_q;
            grant1 =  rr_q;
          end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
          end
`endif
        end
        if (grant0 || grant1) begin
          owner_d  = grant1;
          base_d   = grant1 ? bus.req1_addr : bus.req0_addr;
          len_d    = grant1 ? bus.req1_len  : bus.req0_len;
          cnt_d    = '0;
          rom_en_d = 1'b1;
          state_d  = FIRST;
`ifndef ROM_ARB_PRIO_EN
          rr_d     = ~grant1;
`endif
        end
      end
      FIRST: begin
        rsp_valid_d = 1'b1;
        state_d     = STREAM;
      end
      STREAM: begin
        if (beat_hs) begin
          if (is_last) begin
            rsp_valid_d = 1'b0;
            rom_en_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        rom_en_d    = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rom_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifndef ROM_ARB_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rom_en_q    <= rom_en_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ROM_ARB_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a behavioural 1-cycle ROM whose word encodes its address.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_rom_burst_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  // Expected winners of three consecutive collisions with both ports always requesting.
`ifdef ROM_ARB_PRIO_EN
  localparam logic [2:0] EXP_OWNER = 3'b000;
`else
  localparam logic [2:0] EXP_OWNER = 3'b010;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rom_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rom_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  always @(posedge clk) begin
    if (bus.ROM_read) bus.ROM_out <= rom_f(bus.ROM_address);
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_len = '0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_len = '0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.ROM_out = '0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready: got %b expected 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready: got %b expected 0", bus.req1_ready); end
    checks++; if (bus.ROM_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_enable: got %b expected 0", bus.ROM_enable); end
    checks++; if (bus.ROM_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_read: got %b expected 0", bus.ROM_read); end
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_last, bus.rsp1_last} !== 4'b0) begin errors++; $display("[TB] FAIL reset_rsp: got %b expected 0000", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_last, bus.rsp1_last}); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h010; bus.req0_len = 4'd3; bus.rsp0_ready = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL single_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_first_valid: got %b expected 0", bus.rsp0_valid); end
    checks++; if (bus.ROM_read !== 1'b1) begin errors++; $display("[TB] FAIL single_first_read: got %b expected 1", bus.ROM_read); end
    checks++; if (bus.ROM_address !== 12'h010) begin errors++; $display("[TB] FAIL single_first_addr: got %h expected 010", bus.ROM_address); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      a = 12'h010 + 12'(b);
      checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid beat %0d: got %b expected 1", b, bus.rsp0_valid); end
      checks++; if (bus.rsp0_data !== rom_f(a)) begin errors++; $display("[TB] FAIL single_data beat %0d: got %h expected %h", b, bus.rsp0_data, rom_f(a)); end
      checks++; if (bus.rsp0_last !== (b == 3)) begin errors++; $display("[TB] FAIL single_last beat %0d: got %b expected %b", b, bus.rsp0_last, (b == 3)); end
      checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_other_valid beat %0d: got %b expected 0", b, bus.rsp1_valid); end
    end
    @(negedge clk); #1;
    checks++; if ({bus.rsp0_valid, bus.ROM_enable} !== 2'b00) begin errors++; $display("[TB] FAIL single_idle: got %b expected 00", {bus.rsp0_valid, bus.ROM_enable}); end
  endtask

  task automatic test_arbitration();
    logic              exp;
    logic [ADDR_W-1:0] a0, a1, ea;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      a0 = 12'h100 + 12'(r);
      a1 = 12'h200 + 12'(r);
      bus.req0_valid = 1'b1; bus.req0_addr = a0; bus.req0_len = 4'd0; bus.rsp0_ready = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_addr = a1; bus.req1_len = 4'd0; bus.rsp1_ready = 1'b1;
      exp = EXP_OWNER[r];
      ea  = exp ? a1 : a0;
      #1;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {~exp, exp}) begin errors++; $display("[TB] FAIL arb_grant round %0d: got %b expected %b", r, {bus.req0_ready, bus.req1_ready}, {~exp, exp}); end
      @(negedge clk); #1;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL arb_busy_ready round %0d: got %b expected 00", r, {bus.req0_ready, bus.req1_ready}); end
      checks++; if (bus.ROM_address !== ea) begin errors++; $display("[TB] FAIL arb_addr round %0d: got %h expected %h", r, bus.ROM_address, ea); end
      @(negedge clk); #1;
      checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== {~exp, exp}) begin errors++; $display("[TB] FAIL arb_rsp_valid round %0d: got %b expected %b", r, {bus.rsp0_valid, bus.rsp1_valid}, {~exp, exp}); end
      checks++; if (bus.rsp0_data !== rom_f(ea)) begin errors++; $display("[TB] FAIL arb_data round %0d: got %h expected %h", r, bus.rsp0_data, rom_f(ea)); end
      checks++; if ((bus.rsp0_last | bus.rsp1_last) !== 1'b1) begin errors++; $display("[TB] FAIL arb_last round %0d: got %b expected 1", r, bus.rsp0_last | bus.rsp1_last); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wrap_backpressure();
    logic [ADDR_W-1:0] a;
    int beat = 0;
    int cyc  = 0;
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_addr = 12'hFFE; bus.req1_len = 4'd3; bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.req1_valid = 1'b0;
    while (beat < 4 && cyc < 20) begin
      @(negedge clk);
      bus.rsp1_ready = (cyc % 2 == 0);
      #1;
      a = 12'hFFE + 12'(beat);
      checks++; if (bus.rsp1_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid cyc %0d: got %b expected 1", cyc, bus.rsp1_valid); end
      checks++; if (bus.rsp1_data !== rom_f(a)) begin errors++; $display("[TB] FAIL wrap_data cyc %0d: got %h expected %h", cyc, bus.rsp1_data, rom_f(a)); end
      checks++; if (bus.rsp1_last !== (beat == 3)) begin errors++; $display("[TB] FAIL wrap_last cyc %0d: got %b expected %b", cyc, bus.rsp1_last, (beat == 3)); end
      if (bus.rsp1_ready) beat++;
      cyc++;
    end
    checks++; if (cyc !== 7) begin errors++; $display("[TB] FAIL wrap_cycles: got %0d expected 7", cyc); end
    @(negedge clk);
    bus.rsp1_ready = 1'b1;
    #1;
    checks++; if ({bus.rsp1_valid, bus.ROM_enable} !== 2'b00) begin errors++; $display("[TB] FAIL wrap_idle: got %b expected 00", {bus.rsp1_valid, bus.ROM_enable}); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h020; bus.req0_len = 4'd7; bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 2) begin
        bus.req1_valid = 1'b1; bus.req1_addr = 12'h300; bus.req1_len = 4'd0; bus.rsp1_ready = 1'b1;
      end
      #1;
      a = 12'h020 + 12'(b);
      checks++; if (bus.rsp0_data !== rom_f(a)) begin errors++; $display("[TB] FAIL b2b_data beat %0d: got %h expected %h", b, bus.rsp0_data, rom_f(a)); end
      checks++; if (bus.rsp0_last !== (b == 7)) begin errors++; $display("[TB] FAIL b2b_last beat %0d: got %b expected %b", b, bus.rsp0_last, (b == 7)); end
      if (b >= 2) begin
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wait beat %0d: got %b expected 0", b, bus.req1_ready); end
      end
    end
    @(negedge clk); #1;
    checks++; if ({bus.rsp0_valid, bus.req1_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_handover: got %b expected 01", {bus.rsp0_valid, bus.req1_ready}); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    #1;
    checks++; if (bus.ROM_address !== 12'h300) begin errors++; $display("[TB] FAIL b2b_p1_addr: got %h expected 300", bus.ROM_address); end
    @(negedge clk); #1;
    checks++; if ({bus.rsp1_valid, bus.rsp1_last} !== 2'b11) begin errors++; $display("[TB] FAIL b2b_p1_beat: got %b expected 11", {bus.rsp1_valid, bus.rsp1_last}); end
    checks++; if (bus.rsp1_data !== rom_f(12'h300)) begin errors++; $display("[TB] FAIL b2b_p1_data: got %h expected %h", bus.rsp1_data, rom_f(12'h300)); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h040; bus.req0_len = 4'd7; bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      a = 12'h040 + 12'(b);
      checks++; if (bus.rsp0_data !== rom_f(a)) begin errors++; $display("[TB] FAIL abort_data beat %0d: got %h expected %h", b, bus.rsp0_data, rom_f(a)); end
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.ROM_enable, bus.ROM_read} !== 4'b0) begin errors++; $display("[TB] FAIL abort_outputs: got %b expected 0000", {bus.rsp0_valid, bus.rsp1_valid, bus.ROM_enable, bus.ROM_read}); end
    rst = 1'b0;
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h050; bus.req1_len = 4'd1; bus.rsp1_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_regrant: got %b expected 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); #1;
      a = 12'h050 + 12'(b);
      checks++; if (bus.rsp1_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_fresh_valid beat %0d: got %b expected 1", b, bus.rsp1_valid); end
      checks++; if (bus.rsp1_data !== rom_f(a)) begin errors++; $display("[TB] FAIL abort_fresh_data beat %0d: got %h expected %h", b, bus.rsp1_data, rom_f(a)); end
      checks++; if (bus.rsp1_last !== (b == 1)) begin errors++; $display("[TB] FAIL abort_fresh_last beat %0d: got %b expected %b", b, bus.rsp1_last, (b == 1)); end
    end
    @(negedge clk); #1;
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_fresh_idle: got %b expected 0", bus.rsp1_valid); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_arbitration();
    test_wrap_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
